// File: rtl/line_buffer_window.sv
// Streams raster pixels through KERNEL-1 row buffers and emits one KERNEL-tall
// pixel column per accepted pixel once enough rows are buffered.
module line_buffer_window #(
  parameter int WORDWIDTH  = 32,
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int KERNEL     = 3,
  parameter int COL_BITS   = 5,
  parameter int ROW_BITS   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [WORDWIDTH-1:0]          din,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [KERNEL*WORDWIDTH-1:0]   dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW_BITS-1:0]           out_row,
  output logic [COL_BITS-1:0]           out_col,
  output logic                          out_last
);

  localparam int ADDR_W = (FIG_WIDTH > 2) ? $clog2(FIG_WIDTH) : 1;
  localparam logic [COL_BITS-1:0] LAST_COL      = COL_BITS'(FIG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW      = ROW_BITS'(FIG_HEIGHT - 1);
  localparam logic [ROW_BITS-1:0] FIRST_OUT_ROW = ROW_BITS'(KERNEL - 1);

  // line_mem[0] holds the most recent row, line_mem[KERNEL-2] the oldest
  logic [WORDWIDTH-1:0] line_mem [KERNEL-1][FIG_WIDTH];

  logic [COL_BITS-1:0]        col_cnt;
  logic [ROW_BITS-1:0]        row_cnt;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       accept;
  logic                       produce;
  logic                       col_wrap;
  logic                       frame_end;
  logic [KERNEL*WORDWIDTH-1:0] column_p0;

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready & ~clear;
  assign produce   = accept & (row_cnt >= FIRST_OUT_ROW);
  assign rd_addr   = col_cnt[ADDR_W-1:0];
  assign col_wrap  = (col_cnt == LAST_COL);
  assign frame_end = col_wrap & (row_cnt == LAST_ROW);

  // Stage p0: assemble the column from the live pixel and the old buffer words
  always_comb begin
    column_p0 = '0;
    column_p0[KERNEL*WORDWIDTH-1 -: WORDWIDTH] = din;
    for (int j = 0; j < KERNEL - 1; j++) begin
      column_p0[(KERNEL-2-j)*WORDWIDTH +: WORDWIDTH] = line_mem[j][rd_addr];
    end
  end

  // Rows shift down one buffer per column; reads above see pre-write contents
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][rd_addr] <= din;
      for (int j = 1; j < KERNEL - 1; j++) begin
        line_mem[j][rd_addr] <= line_mem[j-1][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_BITS'(1);
      end else begin
        col_cnt <= col_cnt + COL_BITS'(1);
      end
    end
  end

  // Stage p1: one-entry output register, refilled in the same cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      dout      <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_last  <= frame_end;
      out_row   <= row_cnt;
      out_col   <= col_cnt;
      dout      <= column_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_window.sv
// Scoreboard bench for line_buffer_window: a 4x4 K=3 instance and a 3x2 K=2 instance.
module tb_line_buffer_window;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4x4 image, KERNEL=3
  logic        clear_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic [7:0]  din_a = '0;
  logic        in_ready_a, out_valid_a, out_last_a;
  logic [23:0] dout_a;
  logic [1:0]  out_row_a, out_col_a;

  line_buffer_window #(.WORDWIDTH(8), .FIG_WIDTH(4), .FIG_HEIGHT(4), .KERNEL(3),
                       .COL_BITS(2), .ROW_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .din(din_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .dout(dout_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_row(out_row_a), .out_col(out_col_a),
    .out_last(out_last_a));

  // Instance B: 3x2 image, KERNEL=2
  logic        clear_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic [7:0]  din_b = '0;
  logic        in_ready_b, out_valid_b, out_last_b;
  logic [15:0] dout_b;
  logic [0:0]  out_row_b;
  logic [1:0]  out_col_b;

  line_buffer_window #(.WORDWIDTH(8), .FIG_WIDTH(3), .FIG_HEIGHT(2), .KERNEL(2),
                       .COL_BITS(2), .ROW_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .din(din_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .dout(dout_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_row(out_row_b), .out_col(out_col_b),
    .out_last(out_last_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference image model and expected-output queues
  logic [7:0]  img_a [4][4];
  logic [7:0]  img_b [2][3];
  int          ma_row = 0, ma_col = 0, mb_row = 0, mb_col = 0;
  logic [63:0] qa [$];
  logic [63:0] qb [$];

  int          n_out_a = 0, n_out_b = 0;
  logic [23:0] obs_a_dout [128];
  logic [1:0]  obs_a_row  [128];
  logic [1:0]  obs_a_col  [128];
  logic        obs_a_last [128];
  logic [15:0] obs_b_dout [16];
  logic        obs_b_last [16];

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      ma_row = 0;
      ma_col = 0;
    end else begin
      if (out_valid_a && out_ready_a) begin
        if (n_out_a < 128) begin
          obs_a_dout[n_out_a] = dout_a;
          obs_a_row[n_out_a]  = out_row_a;
          obs_a_col[n_out_a]  = out_col_a;
          obs_a_last[n_out_a] = out_last_a;
        end
        n_out_a++;
        if (qa.size() == 0) chk("a_unexpected_out", 64'({out_last_a, out_row_a, out_col_a, dout_a}), 64'd0);
        else chk("a_out", 64'({out_last_a, out_row_a, out_col_a, dout_a}), qa.pop_front());
      end
      if (clear_a) begin
        qa.delete();
        ma_row = 0;
        ma_col = 0;
      end else if (in_valid_a && in_ready_a) begin
        img_a[ma_row][ma_col] = din_a;
        if (ma_row >= 2)
          qa.push_back(64'({(ma_row == 3 && ma_col == 3), 2'(ma_row), 2'(ma_col),
                            img_a[ma_row][ma_col], img_a[ma_row-1][ma_col], img_a[ma_row-2][ma_col]}));
        if (ma_col == 3) begin
          ma_col = 0;
          ma_row = (ma_row == 3) ? 0 : ma_row + 1;
        end else begin
          ma_col++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      mb_row = 0;
      mb_col = 0;
    end else begin
      if (out_valid_b && out_ready_b) begin
        if (n_out_b < 16) begin
          obs_b_dout[n_out_b] = dout_b;
          obs_b_last[n_out_b] = out_last_b;
        end
        n_out_b++;
        if (qb.size() == 0) chk("b_unexpected_out", 64'({out_last_b, out_row_b, out_col_b, dout_b}), 64'd0);
        else chk("b_out", 64'({out_last_b, out_row_b, out_col_b, dout_b}), qb.pop_front());
      end
      if (clear_b) begin
        qb.delete();
        mb_row = 0;
        mb_col = 0;
      end else if (in_valid_b && in_ready_b) begin
        img_b[mb_row][mb_col] = din_b;
        if (mb_row >= 1)
          qb.push_back(64'({(mb_row == 1 && mb_col == 2), 1'(mb_row), 2'(mb_col),
                            img_b[mb_row][mb_col], img_b[mb_row-1][mb_col]}));
        if (mb_col == 2) begin
          mb_col = 0;
          mb_row = (mb_row == 1) ? 0 : mb_row + 1;
        end else begin
          mb_col++;
        end
      end
    end
  end

  // Present one pixel and wait (bounded) until it is accepted
  task automatic send_a(input logic [7:0] v);
    bit acc = 1'b0;
    int n = 0;
    din_a = v;
    in_valid_a = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_a && !clear_a;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("a_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [7:0] v);
    bit acc = 1'b0;
    int n = 0;
    din_b = v;
    in_valid_b = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_b && !clear_b;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("b_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain_a();
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_out_last",  64'(out_last_a),  64'd0);
    chk("rst_out_row",   64'(out_row_a),   64'd0);
    chk("rst_out_col",   64'(out_col_a),   64'd0);
    chk("rst_dout",      64'(dout_a),      64'd0);
    chk("rst_in_ready",  64'(in_ready_a),  64'd1);

    // Single frame at full throughput
    base = n_out_a;
    for (int i = 0; i < 8; i++) send_a(8'(i));
    chk("t1_no_early_out", 64'(n_out_a - base), 64'd0);
    chk("t1_no_early_valid", 64'(out_valid_a), 64'd0);
    for (int i = 8; i < 16; i++) send_a(8'(i));
    drain_a();
    chk("t1_count", 64'(n_out_a - base), 64'd8);
    chk("t1_first_dout", 64'(obs_a_dout[base]), 64'h080400);
    chk("t1_first_row",  64'(obs_a_row[base]),  64'd2);
    chk("t1_first_col",  64'(obs_a_col[base]),  64'd0);
    chk("t1_first_last", 64'(obs_a_last[base]), 64'd0);
    chk("t1_last_dout",  64'(obs_a_dout[base+7]), 64'h0F0B07);
    chk("t1_last_flag",  64'(obs_a_last[base+7]), 64'd1);
    chk("t1_last_row",   64'(obs_a_row[base+7]),  64'd3);
    chk("t1_last_col",   64'(obs_a_col[base+7]),  64'd3);

    // Downstream stall right after the first column
    base = n_out_a;
    for (int i = 0; i < 9; i++) send_a(8'(i));
    out_ready_a = 1'b0;
    din_a = 8'd9;
    in_valid_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(out_valid_a), 64'd1);
      chk("t2_hold_dout",  64'(dout_a),      64'h080400);
      chk("t2_hold_row",   64'(out_row_a),   64'd2);
      chk("t2_in_ready",   64'(in_ready_a),  64'd0);
      @(posedge clk); #1;
    end
    out_ready_a = 1'b1;
    for (int i = 9; i < 16; i++) send_a(8'(i));
    drain_a();
    chk("t2_count", 64'(n_out_a - base), 64'd8);
    chk("t2_first", 64'(obs_a_dout[base]),   64'h080400);
    chk("t2_second", 64'(obs_a_dout[base+1]), 64'h090501);

    // Two frames back to back
    base = n_out_a;
    for (int i = 0; i < 16; i++) send_a(8'(i));
    for (int i = 100; i < 108; i++) send_a(8'(i));
    chk("t3_no_early_f2", 64'(n_out_a - base), 64'd8);
    for (int i = 108; i < 116; i++) send_a(8'(i));
    drain_a();
    chk("t3_count", 64'(n_out_a - base), 64'd16);
    chk("t3_f2_first", 64'(obs_a_dout[base+8]), {40'd0, 8'd108, 8'd104, 8'd100});
    chk("t3_f2_row",   64'(obs_a_row[base+8]),  64'd2);

    // clear with a column pending
    for (int i = 0; i < 10; i++) send_a(8'(i));
    out_ready_a = 1'b0;
    clear_a = 1'b1;
    din_a = 8'd99;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("t4_cleared_valid", 64'(out_valid_a), 64'd0);
    base = n_out_a;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) send_a(8'(i));
    drain_a();
    chk("t4_count", 64'(n_out_a - base), 64'd8);
    chk("t4_first", 64'(obs_a_dout[base]), 64'h080400);
    chk("t4_row",   64'(obs_a_row[base]),  64'd2);
    chk("t4_col",   64'(obs_a_col[base]),  64'd0);

    // Asynchronous reset during a hold
    for (int i = 0; i < 9; i++) send_a(8'(i));
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_a = 1'b1;
    #1;
    chk("t5_in_ready", 64'(in_ready_a), 64'd1);
    base = n_out_a;
    for (int i = 0; i < 16; i++) send_a(8'(i));
    drain_a();
    chk("t5_count", 64'(n_out_a - base), 64'd8);
    chk("t5_first", 64'(obs_a_dout[base]), 64'h080400);

    // KERNEL=2 instance
    base = n_out_b;
    for (int i = 0; i < 6; i++) send_b(8'(i));
    in_valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("b_count", 64'(n_out_b - base), 64'd3);
    chk("b_out0", 64'(obs_b_dout[base]),   64'h0300);
    chk("b_out1", 64'(obs_b_dout[base+1]), 64'h0401);
    chk("b_out2", 64'(obs_b_dout[base+2]), 64'h0502);
    chk("b_last0", 64'(obs_b_last[base]),   64'd0);
    chk("b_last1", 64'(obs_b_last[base+1]), 64'd0);
    chk("b_last2", 64'(obs_b_last[base+2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
